// File: rtl/clp_ctrl_gen.sv
// ============================================================================
// clp_ctrl_gen
// ----------------------------------------------------------------------------
// Purpose:
//   Control sequencer for one convolution pass over a square feature map.
//   After an accepted start it waits out the compute pipeline fill latency,
//   then sweeps the output map row by row. For each row it enables the compute
//   array for Wo valid columns, followed by a K-1 cycle gap for the line
//   change. A single row stream with no gaps is used when K==1. An optional
//   cycle budget cuts the pass short with a timeout.
//
// Derived quantities (K = kernel size, F = feature size):
//   LAT = 1 if K==1 else K+2     fill latency in cycles
//   Wo  = Ho = F-K+1             output columns / rows
//   gap = K-1                    idle cycles between output rows
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   asynchronous active-high reset
//   start         in   one-cycle request to begin a pass (sampled in IDLE)
//   abort         in   synchronous abort of a running pass
//   kernel_size   in   KS_W   odd kernel size K, captured on accepted start
//   feature_size  in   FEAT_W feature map edge F, captured on accepted start
//   work_time     in   CNT_W  cycle budget, 0 = unlimited
//   busy          out  high in every state except IDLE
//   clp_enable    out  compute array enable, high on valid output columns
//   data_ready    out  same timing as clp_enable
//   row_cnt       out  FEAT_W current output row, 0-based
//   col_cnt       out  FEAT_W current output column, 0-based
//   done          out  one-cycle pulse at pass end (normal or timeout)
//   timeout       out  one-cycle pulse with done when the budget expired
//   cfg_err       out  one-cycle pulse when a start is rejected
// ============================================================================
module clp_ctrl_gen #(
    parameter int CNT_W  = 16,
    parameter int FEAT_W = 8,
    parameter int KS_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [KS_W-1:0]   kernel_size,
    input  logic [FEAT_W-1:0] feature_size,
    input  logic [CNT_W-1:0]  work_time,
    output logic              busy,
    output logic              clp_enable,
    output logic              data_ready,
    output logic [FEAT_W-1:0] row_cnt,
    output logic [FEAT_W-1:0] col_cnt,
    output logic              done,
    output logic              timeout,
    output logic              cfg_err
);

    // The phase counter must reach LAT-1 = K+1, which for the largest
    // representable K needs one bit more than the kernel size itself.
    localparam int PH_W  = KS_W + 1;
    localparam int CMP_W = FEAT_W + KS_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cycleCnt;
    logic [KS_W-1:0]     r_kSize;
    logic [FEAT_W-1:0]   r_fSize;
    logic [CNT_W-1:0]    r_workTime;
    logic [PH_W-1:0]     r_phase;

    logic                w_cfgIllegal;
    logic [CMP_W-1:0]    w_kCmp;
    logic [CMP_W-1:0]    w_fCmp;
    logic [PH_W-1:0]     w_kExt;
    logic [PH_W-1:0]     w_latLast;
    logic [PH_W-1:0]     w_gapLast;
    logic [FEAT_W-1:0]   w_kFeat;
    logic [FEAT_W-1:0]   w_lastIdx;
    logic [CNT_W-1:0]    w_cycNext;
    logic                w_timeUp;
    logic                w_lastCol;
    logic                w_lastRow;
    logic                w_kIsOne;

    // Configuration check on the live inputs: the start decision is made in
    // the same cycle the request is sampled.
    assign w_kCmp       = CMP_W'(kernel_size);
    assign w_fCmp       = CMP_W'(feature_size);
    assign w_cfgIllegal = (kernel_size == '0) || !kernel_size[0] || (w_kCmp > w_fCmp);

    // Values derived from the latched configuration. Wo and Ho are equal for
    // a square map, so a single last-index value serves both counters.
    assign w_kExt    = {1'b0, r_kSize};
    assign w_kIsOne  = (r_kSize == KS_W'(1));
    assign w_latLast = w_kIsOne ? '0 : (w_kExt + PH_W'(1));
    assign w_gapLast = w_kExt - PH_W'(2);
    assign w_kFeat   = FEAT_W'(r_kSize);
    assign w_lastIdx = r_fSize - w_kFeat;
    assign w_lastCol = (col_cnt == w_lastIdx);
    assign w_lastRow = (row_cnt == w_lastIdx);

    // The budget is compared against the value the cycle counter takes at
    // the coming edge, so that the pass is in DONE (and clp_enable is low)
    // exactly at the edge where the counter reaches work_time.
    assign w_cycNext = (r_cycleCnt == {CNT_W{1'b1}}) ? r_cycleCnt : (r_cycleCnt + CNT_W'(1));
    assign w_timeUp  = (r_workTime != '0) && (w_cycNext == r_workTime);

    // Single sequencer: state, counters, latched configuration and every
    // output are registered here. Priority inside a busy state is
    // abort > natural completion > timeout > normal progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cycleCnt <= '0;
            r_kSize    <= '0;
            r_fSize    <= '0;
            r_workTime <= '0;
            r_phase    <= '0;
            busy       <= 1'b0;
            clp_enable <= 1'b0;
            data_ready <= 1'b0;
            row_cnt    <= '0;
            col_cnt    <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            cfg_err <= 1'b0;

            if (r_state != S_IDLE) begin
                r_cycleCnt <= w_cycNext;
            end

            if ((r_state != S_IDLE) && abort) begin
                r_state    <= S_IDLE;
                busy       <= 1'b0;
                clp_enable <= 1'b0;
                data_ready <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (w_cfgIllegal) begin
                                cfg_err <= 1'b1;
                            end else begin
                                r_state    <= S_FILL;
                                busy       <= 1'b1;
                                r_cycleCnt <= '0;
                                r_phase    <= '0;
                                row_cnt    <= '0;
                                col_cnt    <= '0;
                                r_kSize    <= kernel_size;
                                r_fSize    <= feature_size;
                                r_workTime <= work_time;
                            end
                        end
                    end

                    S_FILL: begin
                        if (w_timeUp) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            timeout <= 1'b1;
                        end else if (r_phase == w_latLast) begin
                            r_state    <= S_RUN;
                            clp_enable <= 1'b1;
                            data_ready <= 1'b1;
                        end else begin
                            r_phase <= r_phase + PH_W'(1);
                        end
                    end

                    S_RUN: begin
                        if (w_lastCol && w_lastRow) begin
                            r_state    <= S_DONE;
                            done       <= 1'b1;
                            clp_enable <= 1'b0;
                            data_ready <= 1'b0;
                        end else if (w_timeUp) begin
                            r_state    <= S_DONE;
                            done       <= 1'b1;
                            timeout    <= 1'b1;
                            clp_enable <= 1'b0;
                            data_ready <= 1'b0;
                        end else if (w_lastCol) begin
                            // A 1x1 kernel needs no line change, so the next
                            // row follows immediately.
                            if (w_kIsOne) begin
                                row_cnt <= row_cnt + FEAT_W'(1);
                                col_cnt <= '0;
                            end else begin
                                r_state    <= S_GAP;
                                r_phase    <= '0;
                                clp_enable <= 1'b0;
                                data_ready <= 1'b0;
                            end
                        end else begin
                            col_cnt <= col_cnt + FEAT_W'(1);
                        end
                    end

                    S_GAP: begin
                        if (w_timeUp) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            timeout <= 1'b1;
                        end else if (r_phase == w_gapLast) begin
                            r_state    <= S_RUN;
                            row_cnt    <= row_cnt + FEAT_W'(1);
                            col_cnt    <= '0;
                            clp_enable <= 1'b1;
                            data_ready <= 1'b1;
                        end else begin
                            r_phase <= r_phase + PH_W'(1);
                        end
                    end

                    S_DONE: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end

                    default: begin
                        r_state    <= S_IDLE;
                        busy       <= 1'b0;
                        clp_enable <= 1'b0;
                        data_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clp_ctrl_gen.sv
// ============================================================================
// tb_clp_ctrl_gen
// ----------------------------------------------------------------------------
// Purpose:
//   Self-checking bench for clp_ctrl_gen. A table of configurations with
//   hand-derived landmarks (first/last enable, done offset, timeout, enable
//   count, cfg_err) is applied in a loop. Hand sequences then cover abort in
//   a gap, abort together with start, and asynchronous reset mid-run.
//   Finally, randomized passes are compared cycle by cycle against an
//   arithmetic model of the output timeline.
//   KS_W is widened to 4 so that kernel sizes up to 15 can be exercised.
// ============================================================================
module tb_clp_ctrl_gen;

    localparam int CNT_W  = 16;
    localparam int FEAT_W = 8;
    localparam int KS_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [KS_W-1:0]   kernel_size = '0;
    logic [FEAT_W-1:0] feature_size = '0;
    logic [CNT_W-1:0]  work_time = '0;
    logic              busy;
    logic              clp_enable;
    logic              data_ready;
    logic [FEAT_W-1:0] row_cnt;
    logic [FEAT_W-1:0] col_cnt;
    logic              done;
    logic              timeout;
    logic              cfg_err;

    int checks = 0;
    int errors = 0;

    clp_ctrl_gen #(
        .CNT_W (CNT_W),
        .FEAT_W(FEAT_W),
        .KS_W  (KS_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .kernel_size (kernel_size),
        .feature_size(feature_size),
        .work_time   (work_time),
        .busy        (busy),
        .clp_enable  (clp_enable),
        .data_ready  (data_ready),
        .row_cnt     (row_cnt),
        .col_cnt     (col_cnt),
        .done        (done),
        .timeout     (timeout),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              busy;
        logic              en;
        logic              dr;
        logic              done;
        logic              to;
        logic              err;
        logic [FEAT_W-1:0] row;
        logic [FEAT_W-1:0] col;
    } obs_t;

    typedef struct {
        int k;
        int f;
        int wt;
        int expErr;
        int expFirst;
        int expLast;
        int expDone;
        int expTo;
        int expCount;
    } vec_t;

    vec_t vecs[13];

    // Inputs are driven 1ns after the rising edge and outputs sampled there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t sampleDut();
        obs_t o;
        o.busy = busy;
        o.en   = clp_enable;
        o.dr   = data_ready;
        o.done = done;
        o.to   = timeout;
        o.err  = cfg_err;
        o.row  = row_cnt;
        o.col  = col_cnt;
        return o;
    endfunction

    function automatic obs_t maskRc(input obs_t o);
        obs_t m;
        m     = o;
        m.row = '0;
        m.col = '0;
        return m;
    endfunction

    task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got busy=%0b en=%0b dr=%0b done=%0b to=%0b err=%0b row=%0d col=%0d, want busy=%0b en=%0b dr=%0b done=%0b to=%0b err=%0b row=%0d col=%0d",
                     name, $time, act.busy, act.en, act.dr, act.done, act.to, act.err, act.row, act.col,
                     exp.busy, exp.en, exp.dr, exp.done, exp.to, exp.err, exp.row, exp.col);
        end
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input int k, input int f, input int wt);
        kernel_size  = KS_W'(k);
        feature_size = FEAT_W'(f);
        work_time    = CNT_W'(wt);
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic bit isLegal(input int k, input int f);
        return (k != 0) && (k % 2 == 1) && (k <= f);
    endfunction

    function automatic int latOf(input int k);
        return (k == 1) ? 1 : k + 2;
    endfunction

    // Offset (edges after the accepted start) at which done is expected.
    function automatic int naturalDone(input int k, input int f);
        int wo;
        wo = f - k + 1;
        return latOf(k) + (wo - 1) * (wo + k - 1) + wo;
    endfunction

    function automatic int endOf(input int k, input int f, input int wt);
        int dn;
        dn = naturalDone(k, f);
        return (wt != 0 && wt < dn) ? wt : dn;
    endfunction

    // Position inside the sweep at offset m, while the pass is still running.
    function automatic obs_t posOf(input int m, input int k, input int f);
        obs_t o;
        int lat, wo, per, q;
        o    = '0;
        lat  = latOf(k);
        wo   = f - k + 1;
        per  = wo + k - 1;
        o.busy = 1'b1;
        if (m >= lat) begin
            q     = m - lat;
            o.row = FEAT_W'(q / per);
            if ((q % per) < wo) begin
                o.en  = 1'b1;
                o.dr  = 1'b1;
                o.col = FEAT_W'(q % per);
            end else begin
                o.col = FEAT_W'(wo - 1);
            end
        end
        return o;
    endfunction

    function automatic obs_t modelAt(input int n, input int k, input int f, input int wt, input int abortOff);
        obs_t o;
        int endOff;
        bit isTo;
        endOff = endOf(k, f, wt);
        isTo   = (wt != 0) && (wt < naturalDone(k, f));
        if (abortOff >= 0 && n > abortOff) begin
            o      = posOf(abortOff, k, f);
            o.busy = 1'b0;
            o.en   = 1'b0;
            o.dr   = 1'b0;
            return o;
        end
        if (n < endOff) return posOf(n, k, f);
        o    = posOf(endOff - 1, k, f);
        o.en = 1'b0;
        o.dr = 1'b0;
        if (n == endOff) begin
            o.done = 1'b1;
            o.to   = isTo;
        end else begin
            o.busy = 1'b0;
        end
        return o;
    endfunction

    // One full pass compared cycle by cycle with the model; optional abort
    // and spurious start/config changes while busy.
    task automatic runModel(input int k, input int f, input int wt, input int abortOff, input bit spam);
        obs_t exp;
        int endOff, last, stopDrive;
        applyStimulus(k, f, wt);
        if (!isLegal(k, f)) begin
            exp     = '0;
            exp.err = 1'b1;
            checkOutput("rndCfgErr", maskRc(sampleDut()), exp);
            tick();
            checkOutput("rndCfgErrEnd", maskRc(sampleDut()), '0);
            return;
        end
        endOff    = endOf(k, f, wt);
        last      = (abortOff >= 0) ? abortOff + 1 : endOff + 1;
        stopDrive = (abortOff >= 0) ? abortOff : endOff;
        for (int n = 0; n <= last; n++) begin
            if (n > 0) tick();
            exp = modelAt(n, k, f, wt, abortOff);
            checkOutput("rndStep", sampleDut(), exp);
            abort = (n == abortOff);
            if (spam && n <= stopDrive) begin
                start        = ($urandom_range(0, 3) == 0);
                kernel_size  = KS_W'($urandom);
                feature_size = FEAT_W'($urandom);
                work_time    = CNT_W'($urandom_range(0, 5));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Table vector: measure landmarks of the pass and compare with constants.
    task automatic runVector(input vec_t v);
        obs_t s;
        int firstEn, lastEn, cnt, doneOff, toSeen, errCnt, busyAny, n;
        bit fin;
        firstEn = -1; lastEn = -1; cnt = 0; doneOff = -1;
        toSeen = 0; errCnt = 0; busyAny = 0; n = 0; fin = 1'b0;
        applyStimulus(v.k, v.f, v.wt);
        while (!fin && n < 600) begin
            if (n > 0) tick();
            s = sampleDut();
            if (s.en) begin
                if (firstEn < 0) firstEn = n;
                lastEn = n;
                cnt++;
            end
            if (s.err) errCnt++;
            if (s.busy) busyAny = 1;
            if (s.done && doneOff < 0) begin
                doneOff = n;
                toSeen  = s.to;
            end
            if (doneOff >= 0 && n == doneOff + 1) begin
                checkVal("vecBusyAfterDone", int'(s.busy), 0);
                fin = 1'b1;
            end
            if (v.expErr != 0 && n == 4) fin = 1'b1;
            n++;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("[TB] FAIL vecBudget K=%0d F=%0d: no done within 600 cycles, want done at %0d", v.k, v.f, v.expDone);
        end
        checkVal("vecErr", errCnt, v.expErr);
        checkVal("vecCount", cnt, v.expCount);
        if (v.expErr != 0) begin
            checkVal("vecErrBusy", busyAny, 0);
        end else begin
            checkVal("vecFirst", firstEn, v.expFirst);
            checkVal("vecLast", lastEn, v.expLast);
            checkVal("vecDone", doneOff, v.expDone);
            checkVal("vecTimeout", toSeen, v.expTo);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        obs_t exp;
        int k, f, wt, ab, maxK;

        //           k  f  wt  err first last done to count
        vecs[0]  = '{3, 8,  0, 0,  5,  50, 51, 0, 36};
        vecs[1]  = '{1, 4,  0, 0,  1,  16, 17, 0, 16};
        vecs[2]  = '{3, 8, 10, 0,  5,   9, 10, 1,  5};
        vecs[3]  = '{4, 8,  0, 1, -1,  -1, -1, 0,  0};
        vecs[4]  = '{9, 8,  0, 1, -1,  -1, -1, 0,  0};
        vecs[5]  = '{5, 12, 0, 0,  7,  98, 99, 0, 64};
        vecs[6]  = '{3, 3,  0, 0,  5,   5,  6, 0,  1};
        vecs[7]  = '{3, 8, 51, 0,  5,  50, 51, 0, 36};
        vecs[8]  = '{3, 8, 50, 0,  5,  49, 50, 1, 35};
        vecs[9]  = '{1, 1,  0, 0,  1,   1,  2, 0,  1};
        vecs[10] = '{0, 8,  0, 1, -1,  -1, -1, 0,  0};
        vecs[11] = '{3, 8,  3, 0, -1,  -1,  3, 1,  0};
        vecs[12] = '{15, 15, 0, 0, 17, 17, 18, 0,  1};

        // Reset state
        #2;
        checkOutput("resetState", sampleDut(), '0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("postReset", sampleDut(), '0);

        // Table-driven landmark checks
        for (int i = 0; i < 13; i++) begin
            runVector(vecs[i]);
            tick();
        end

        // Abort during the gap after row 2 (K=5, F=12: offsets 39..42)
        applyStimulus(5, 12, 0);
        for (int n = 1; n <= 40; n++) tick();
        checkVal("gapEnLow", int'(clp_enable), 0);
        checkVal("gapRow", int'(row_cnt), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp = '0;
        checkOutput("abortGap", maskRc(sampleDut()), exp);
        for (int n = 0; n < 5; n++) begin
            tick();
            checkOutput("abortNoDone", maskRc(sampleDut()), exp);
        end
        runVector(vecs[5]);
        tick();

        // abort together with start in IDLE: start wins
        kernel_size  = KS_W'(3);
        feature_size = FEAT_W'(8);
        work_time    = '0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkVal("abortStartBusy", int'(busy), 1);
        for (int n = 1; n <= 5; n++) tick();
        checkVal("abortStartEn", int'(clp_enable), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkVal("abortRunBusy", int'(busy), 0);
        tick();

        // Asynchronous reset mid-RUN, with a start pulse while busy beforehand
        applyStimulus(3, 8, 0);
        tick();
        kernel_size  = KS_W'(1);
        feature_size = FEAT_W'(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 3; n <= 7; n++) tick();
        exp = posOf(7, 3, 8);
        checkOutput("busyStartIgnored", sampleDut(), exp);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("asyncReset", sampleDut(), '0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        runVector(vecs[1]);
        tick();

        // Randomized passes against the model
        for (int it = 0; it < 40; it++) begin
            f = $urandom_range(1, 20);
            maxK = (f < 15) ? f : 15;
            if ($urandom_range(0, 4) == 0) begin
                k = ($urandom_range(0, 1) == 0) ? 2 * $urandom_range(0, 7) : 15;
            end else begin
                k = 2 * $urandom_range(0, (maxK - 1) / 2) + 1;
            end
            wt = 0;
            ab = -1;
            if (isLegal(k, f)) begin
                if ($urandom_range(0, 1) == 0) wt = $urandom_range(1, naturalDone(k, f) + 2);
                if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, endOf(k, f, wt) - 1);
            end
            runModel(k, f, wt, ab, $urandom_range(0, 1) == 1);
            for (int g = 0; g < $urandom_range(1, 3); g++) begin
                abort = $urandom_range(0, 1) == 1;
                tick();
                checkOutput("rndIdle", maskRc(sampleDut()), '0);
            end
            abort = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clp_ctrl_gen.md
CLP_CTRL_GEN -- requirements
Module: clp_ctrl_gen

Interface
REQ-001 Parameters SHALL be: CNT_W, default 16, cycle-counter/work-time width; FEAT_W, default 8, feature/row/column width; KS_W, default 3, kernel-size width.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle request to begin one convolution pass; sampled only in IDLE.
REQ-005 abort  in  1  synchronous abort of a running pass.
REQ-006 kernel_size  in  KS_W  odd kernel size K; captured on accepted start.
REQ-007 feature_size  in  FEAT_W  input feature map edge F; captured on accepted start.
REQ-008 work_time  in  CNT_W  cycle budget; 0 = unlimited; captured on accepted start.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 clp_enable  out  1  compute array enable; high only on valid output columns.
REQ-011 data_ready  out  1  registered copy of valid-column condition, same timing as clp_enable.
REQ-012 row_cnt  out  FEAT_W  current output row, 0-based.
REQ-013 col_cnt  out  FEAT_W  current output column, 0-based.
REQ-014 done  out  1  one-cycle pulse at pass end (normal or timeout).
REQ-015 timeout  out  1  one-cycle pulse coincident with done when pass ended on work_time.
REQ-016 cfg_err  out  1  one-cycle pulse when start is rejected for illegal config.

Function
REQ-017 States SHALL be IDLE, FILL, RUN, GAP, DONE; all outputs registered.
REQ-018 Derived values: LAT = 1 if K==1 else K+2; Wo = F-K+1 output columns; Ho = F-K+1 output rows; GAP length K-1 cycles.
REQ-019 Config is illegal if K==0, K even, or K>F; start with illegal config SHALL pulse cfg_err next cycle and remain IDLE.
REQ-020 Accepted start at edge T: state FILL, cycle_cnt=0, row_cnt=0, col_cnt=0, config latched; input changes afterwards ignored.
REQ-021 cycle_cnt (CNT_W bits) SHALL increment every cycle while busy; saturates at all-ones, no wrap.
REQ-022 FILL SHALL last LAT cycles; clp_enable and data_ready first high at edge T+LAT.
REQ-023 RUN: clp_enable=data_ready=1, col_cnt increments per cycle from 0 to Wo-1.
REQ-024 At col_cnt==Wo-1: if row_cnt==Ho-1 go DONE; else if K==1 go RUN with row_cnt+1, col_cnt=0 (no bubble); else go GAP.
REQ-025 GAP: clp_enable=data_ready=0 for K-1 cycles, then RUN with row_cnt+1, col_cnt=0.
REQ-026 DONE: done=1 for one cycle, clp_enable=0, then IDLE; row_cnt/col_cnt hold last values until next accepted start.
REQ-027 If work_time!=0 and cycle_cnt==work_time in FILL/RUN/GAP, next state DONE with timeout=1 alongside done; clp_enable drops at that same edge.
REQ-028 Timeout and natural completion on same cycle: done=1, timeout=0 (completion wins).
REQ-029 abort in FILL/RUN/GAP/DONE: next state IDLE, clp_enable=data_ready=0, no done, no timeout; abort in IDLE ignored.
REQ-030 abort and start in same cycle in IDLE: start accepted.
REQ-031 start while busy SHALL be ignored, no error pulse.

Reset
REQ-032 rst high SHALL immediately force IDLE; busy, clp_enable, data_ready, done, timeout, cfg_err = 0; row_cnt, col_cnt, cycle_cnt = 0; latched config = 0.
REQ-033 Reset mid-pass SHALL discard the pass; first start after rst deasserts is accepted normally.

Verification
REQ-034 K=3, F=8, work_time=0, start at T -> clp_enable high T+5..T+10, low 2 cycles, six 6-column rows total, last valid T+50, done at T+51, busy low T+52.
REQ-035 K=1, F=4, start at T -> clp_enable continuous T+1..T+16, row_cnt 0..3, done T+17, no gap cycles.
REQ-036 K=3, F=8, work_time=10 -> clp_enable low from edge where cycle_cnt==10, done and timeout pulse together, IDLE next cycle.
REQ-037 K=4 or K=9 with F=8 -> cfg_err single pulse, busy stays 0, clp_enable never high.
REQ-038 K=5, F=12, abort asserted during GAP of row 2 -> IDLE next cycle, no done; subsequent start runs full pass (8 rows x 8 cols, gap 4).
REQ-039 rst asserted asynchronously mid-RUN -> all outputs 0 without clock edge; start repeated while busy produces no effect.
